// File: rtl/pipeline_perf_monitor_if.sv
// Strobe and display bus between the CPU core / board switches and the
// performance monitor. The core side drives events; the monitor returns the display word.
interface pipeline_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             pc_enable;
  logic             jmp;
  logic             branchif;
  logic             load_use;
  logic             show_valid;
  logic [CNT_W-1:0] leddata_in;
  logic             clr;
  logic [1:0]       select;
  logic             show_load_use;
  logic [CNT_W-1:0] leddata_out;

  modport master (
    output pc_enable,
    output jmp,
    output branchif,
    output load_use,
    output show_valid,
    output leddata_in,
    output clr,
    output select,
    output show_load_use,
    input  leddata_out
  );

  modport slave (
    input  pc_enable,
    input  jmp,
    input  branchif,
    input  load_use,
    input  show_valid,
    input  leddata_in,
    input  clr,
    input  select,
    input  show_load_use,
    output leddata_out
  );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Saturating cycle/jump/branch/load-use counters plus the syscall display
// register, multiplexed by the board switches into a registered display word.
module pipeline_perf_monitor #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  CPU_RESETN,
  pipeline_perf_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != CNT_MAX)) begin
      return cnt + CNT_ONE;
    end
    return cnt;
  endfunction

  logic             inc_cyc;
  logic             inc_jmp;
  logic             inc_br;
  logic             inc_lu;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] jmp_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] show_reg;
  logic [CNT_W-1:0] src_sel;
  logic [CNT_W-1:0] leddata_p1;

  // A halted pipeline freezes every event counter, regardless of stray strobes.
  always_comb begin
    inc_cyc = mon.pc_enable;
    inc_jmp = mon.pc_enable & mon.jmp;
    inc_br  = mon.pc_enable & mon.branchif;
    inc_lu  = mon.pc_enable & mon.load_use;
  end

  // Stage p0: accumulators and display capture (clr > increment > hold)
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cyc_cnt  <= '0;
      jmp_cnt  <= '0;
      br_cnt   <= '0;
      lu_cnt   <= '0;
      show_reg <= '0;
    end else if (mon.clr) begin
      cyc_cnt  <= '0;
      jmp_cnt  <= '0;
      br_cnt   <= '0;
      lu_cnt   <= '0;
      show_reg <= '0;
    end else begin
      cyc_cnt <= sat_inc(cyc_cnt, inc_cyc);
      jmp_cnt <= sat_inc(jmp_cnt, inc_jmp);
      br_cnt  <= sat_inc(br_cnt, inc_br);
      lu_cnt  <= sat_inc(lu_cnt, inc_lu);
      // The halting syscall sits in WB, so capture ignores pc_enable.
      if (mon.show_valid) begin
        show_reg <= mon.leddata_in;
      end
    end
  end

  always_comb begin
    src_sel = show_reg;
    case (mon.select)
      2'b00:   src_sel = mon.show_load_use ? lu_cnt : show_reg;
      2'b01:   src_sel = cyc_cnt;
      2'b10:   src_sel = jmp_cnt;
      default: src_sel = br_cnt;
    endcase
  end

  // Stage p1: registered display word, so switch changes never glitch the driver
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      leddata_p1 <= '0;
    end else begin
      leddata_p1 <= src_sel;
    end
  end

  assign mon.leddata_out = leddata_p1;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: a 32-bit and a 4-bit instance share one stimulus
// stream and are compared each cycle against an event-count reference model.
module tb_pipeline_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_enable, jmp, branchif, load_use, show_valid, clr, show_load_use;
  logic [1:0]  select;
  logic [31:0] leddata_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_perf_monitor_if #(.CNT_W(32)) bus32 ();
  pipeline_perf_monitor_if #(.CNT_W(4))  bus4 ();

  assign bus32.pc_enable     = pc_enable;
  assign bus32.jmp           = jmp;
  assign bus32.branchif      = branchif;
  assign bus32.load_use      = load_use;
  assign bus32.show_valid    = show_valid;
  assign bus32.leddata_in    = leddata_in;
  assign bus32.clr           = clr;
  assign bus32.select        = select;
  assign bus32.show_load_use = show_load_use;

  assign bus4.pc_enable     = pc_enable;
  assign bus4.jmp           = jmp;
  assign bus4.branchif      = branchif;
  assign bus4.load_use      = load_use;
  assign bus4.show_valid    = show_valid;
  assign bus4.leddata_in    = leddata_in[3:0];
  assign bus4.clr           = clr;
  assign bus4.select        = select;
  assign bus4.show_load_use = show_load_use;

  pipeline_perf_monitor #(.CNT_W(32)) dut (
    .clk        (clk),
    .CPU_RESETN (rst_n),
    .mon        (bus32.slave)
  );

  pipeline_perf_monitor #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .CPU_RESETN (rst_n),
    .mon        (bus4.slave)
  );

  // Reference model: raw event counts since the last clear/reset; saturation
  // is applied only when a value is read out at a given width.
  longint unsigned n_cyc, n_jmp, n_br, n_lu;
  logic [31:0]     show_m;
  logic [31:0]     exp32, exp4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input longint unsigned n, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (n > mx) ? mx[31:0] : n[31:0];
  endfunction

  function automatic logic [31:0] src(input int w);
    logic [31:0] mask;
    mask = sat(64'hFFFF_FFFF_FFFF_FFFF, w);
    case (select)
      2'd0:    return show_load_use ? sat(n_lu, w) : (show_m & mask);
      2'd1:    return sat(n_cyc, w);
      2'd2:    return sat(n_jmp, w);
      default: return sat(n_br, w);
    endcase
  endfunction

  task automatic model_clear();
    n_cyc  = 0;
    n_jmp  = 0;
    n_br   = 0;
    n_lu   = 0;
    show_m = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      exp32 = '0;
      exp4  = '0;
    end else begin
      exp32 = src(32);
      exp4  = src(4);
      if (clr) begin
        model_clear();
      end else begin
        if (pc_enable) begin
          n_cyc++;
          if (jmp)      n_jmp++;
          if (branchif) n_br++;
          if (load_use) n_lu++;
        end
        if (show_valid) show_m = leddata_in;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out32", bus32.leddata_out, exp32);
    check_eq("out4", {28'd0, bus4.leddata_out}, exp4);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    exp32 = '0;
    exp4  = '0;
    check_eq("rst_async32", bus32.leddata_out, 32'd0);
    check_eq("rst_async4", {28'd0, bus4.leddata_out}, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_strobes();
    jmp        = 1'b0;
    branchif   = 1'b0;
    load_use   = 1'b0;
    show_valid = 1'b0;
    clr        = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    pc_enable     = 1'b1;
    jmp           = 1'b1;
    branchif      = 1'b1;
    load_use      = 1'b1;
    show_valid    = 1'b1;
    clr           = 1'b0;
    select        = 2'd1;
    show_load_use = 1'b1;
    leddata_in    = 32'hDEAD_BEEF;
    model_clear();
    #1;
    check_eq("reset32", bus32.leddata_out, 32'd0);
    check_eq("reset4", {28'd0, bus4.leddata_out}, 32'd0);
    @(negedge clk);
    repeat (3) step();

    // Release and count 10 enabled cycles.
    rst_n         = 1'b1;
    idle_strobes();
    show_load_use = 1'b0;
    select        = 2'd1;
    repeat (10) step();
    check_eq("idle9", bus32.leddata_out, 32'd9);

    // Gating: strobes ignored while halted.
    clr = 1'b1;
    step();
    clr       = 1'b0;
    pc_enable = 1'b0;
    jmp       = 1'b1;
    branchif  = 1'b1;
    load_use  = 1'b1;
    repeat (5) step();
    pc_enable = 1'b1;
    repeat (3) step();
    pc_enable = 1'b0;
    select    = 2'd2;
    step();
    check_eq("jmp3", bus32.leddata_out, 32'd3);
    select = 2'd3;
    step();
    check_eq("br3", bus32.leddata_out, 32'd3);
    select        = 2'd0;
    show_load_use = 1'b1;
    step();
    check_eq("lu3", bus32.leddata_out, 32'd3);

    // Display capture, held across halted cycles.
    idle_strobes();
    show_load_use = 1'b0;
    show_valid    = 1'b1;
    leddata_in    = 32'h0000_0022;
    step();
    show_valid = 1'b0;
    leddata_in = $urandom;
    step();
    check_eq("disp22", bus32.leddata_out, 32'h22);
    repeat (3) step();
    check_eq("disp_hold", bus32.leddata_out, 32'h22);

    // Clear priority over increment and capture.
    select    = 2'd2;
    pc_enable = 1'b1;
    jmp       = 1'b1;
    repeat (3) step();
    clr        = 1'b1;
    show_valid = 1'b1;
    leddata_in = 32'd5;
    step();
    clr        = 1'b0;
    show_valid = 1'b0;
    step();
    check_eq("clr_jmp0", bus32.leddata_out, 32'd0);
    jmp       = 1'b0;
    pc_enable = 1'b0;
    step();
    check_eq("jmp_after_clr", bus32.leddata_out, 32'd1);
    select = 2'd0;
    step();
    check_eq("clr_show0", bus32.leddata_out, 32'd0);

    // Async reset mid-run.
    select    = 2'd3;
    pc_enable = 1'b1;
    branchif  = 1'b1;
    repeat (7) step();
    pc_enable = 1'b0;
    step();
    check_eq("br7", bus32.leddata_out, 32'd7);
    pulse_reset();
    pc_enable = 1'b1;
    repeat (2) step();
    pc_enable = 1'b0;
    step();
    check_eq("br_restart", bus32.leddata_out, 32'd2);

    // Saturation on the 4-bit instance.
    idle_strobes();
    clr = 1'b1;
    step();
    clr       = 1'b0;
    select    = 2'd1;
    pc_enable = 1'b1;
    repeat (20) step();
    check_eq("sat4", {28'd0, bus4.leddata_out}, 32'd15);
    check_eq("nosat32", bus32.leddata_out, 32'd19);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      pc_enable  = ($urandom_range(0, 7) != 0);
      jmp        = ($urandom_range(0, 2) == 0);
      branchif   = ($urandom_range(0, 2) == 0);
      load_use   = ($urandom_range(0, 3) == 0);
      show_valid = ($urandom_range(0, 4) == 0);
      leddata_in = $urandom;
      clr        = ($urandom_range(0, 96) == 0);
      if ($urandom_range(0, 5) == 0) begin
        select        = 2'($urandom_range(0, 3));
        show_load_use = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 210) == 0) pulse_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_perf_monitor.md
# pipeline_perf_monitor

Performance-counter and display-source block for the 5-stage pipelined MIPS CPU. It sits downstream of the CPU core and upstream of the seven-segment display driver. It consumes the core's hazard, flush and enable strobes plus the WB-stage syscall display value. It produces the 32-bit word the display driver shows, selected by the board switches.

## Interface
Parameters:
- CNT_W, 32, width of every counter and of the display word

Ports:
- clk  in  1  divided CPU clock, same clock as the pipeline registers
- CPU_RESETN  in  1  asynchronous active-low reset
- pc_enable  in  1  pipeline running (0 while halted on a syscall)
- jmp  in  1  EX-stage unconditional jump (j/jal/jr) flushing IF/ID
- branchif  in  1  EX-stage conditional branch taken
- load_use  in  1  ID-stage load-use stall
- show_valid  in  1  WB-stage syscall display request is valid this cycle
- leddata_in  in  CNT_W  WB-stage syscall display value
- clr  in  1  synchronous clear of all counters and the display register
- select  in  2  display source select (board switches)
- show_load_use  in  1  alternate source for select=00 (board switch 15)
- leddata_out  out  CNT_W  registered word to the display driver

## Operation
- Four counters: cyc_cnt, jmp_cnt, br_cnt, lu_cnt, all CNT_W bits wide. Plus one display register, show_reg.
- Increment conditions, evaluated each rising clk edge:
  - cyc_cnt: pc_enable=1
  - jmp_cnt: pc_enable & jmp
  - br_cnt: pc_enable & branchif
  - lu_cnt: pc_enable & load_use
- No counter changes while pc_enable=0, whatever the other strobes are doing.
- jmp, branchif and load_use asserted together in one cycle: each qualifying counter increments by 1, independently.
- Counters saturate at all-ones. At all-ones an increment condition leaves the value unchanged. Counters never wrap.
- show_reg loads leddata_in on any edge where show_valid=1. This is independent of pc_enable, because the halting syscall itself is in WB.
- clr=1: all four counters and show_reg go to 0 on that edge. clr has priority over every increment and over the show_valid load.
- Source mux feeding the leddata_out register:
  - select=00, show_load_use=0: show_reg
  - select=00, show_load_use=1: lu_cnt
  - select=01: cyc_cnt
  - select=10: jmp_cnt
  - select=11: br_cnt
- The mux reads the counter and show_reg values before the current edge's update, i.e. the registered values.
- No state machine. Each counter is a saturating accumulator with the priority order clr > increment > hold.

## Timing
- Reset (CPU_RESETN=0, asynchronous, no clock needed): all counters, show_reg and leddata_out are 0.
- Reset deasserted mid-run: counting resumes on the first rising edge at which CPU_RESETN=1.
- Update latency:
  - An increment condition at edge N is visible in the counter after edge N.
  - It appears on leddata_out after edge N+1.
  - Total: 2 edges from strobe to display.
- select or show_load_use change: leddata_out reflects the new source after the next edge (1-cycle latency). No glitch path exists from the switches to the output.
- show_valid at edge N: show_reg holds leddata_in after edge N. With select=00 and show_load_use=0, leddata_out shows it after edge N+1.
- clr at edge N: counters are 0 after edge N. leddata_out is 0 after edge N+1 for every select value.
- All inputs are sampled only at rising clk. Strobes are level-qualified per cycle; a strobe held for k enabled cycles counts k.

## Test plan
- Reset then idle: hold CPU_RESETN=0 for 3 cycles with all strobes set to 1 and pc_enable=1 -> leddata_out=0 and all counters 0 throughout. Then release with pc_enable=1 for 10 cycles and select=01 -> leddata_out reads 9 one cycle after the 10th edge (counter=10, output lags by one).
- Gating: pc_enable=0 for 5 cycles with jmp=branchif=load_use=1 -> all counters unchanged. Set pc_enable=1 for 3 cycles with the same strobes -> jmp_cnt=br_cnt=lu_cnt=3, checked via select=10, 11, and 00 with show_load_use=1.
- Display capture: show_valid=1 for one cycle with leddata_in=32'h0000_0022, select=00, show_load_use=0 -> leddata_out=32'h22 two edges after the strobe's edge. It stays there after show_valid drops, including while pc_enable=0.
- Saturation: force cyc_cnt to 32'hFFFF_FFFE (or set CNT_W=4 and run 20 enabled cycles) -> the count reaches all-ones, stays there, never reads 0.
- Clear priority: in the same cycle assert clr=1, pc_enable=1, jmp=1 and show_valid=1 with leddata_in=5 -> every counter and show_reg reads 0. The next enabled cycle with jmp=1 gives jmp_cnt=1.
- Async reset mid-operation: after 7 counted branches, pulse CPU_RESETN low for less than one clk period between edges -> leddata_out goes to 0 immediately, before the next edge, and br_cnt restarts from 0.
